// File: rtl/oci_trace_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | oci_trace_pkg                                                               |
// | Shared constants and state encoding for the OCI direct-conditional packer. |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package oci_trace_pkg;

  localparam int CODE_W = 2;
  localparam int SLOTS  = 15;
  localparam int BUF_W  = CODE_W * SLOTS;
  localparam int CNT_W  = 4;

  localparam logic [CODE_W-1:0] CODE_NT  = 2'b10;
  localparam logic [CODE_W-1:0] CODE_TK  = 2'b11;
  localparam logic [CODE_W-1:0] CODE_EXC = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sramqsys_cpu_oci_frame_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sramqsys_cpu_oci_frame_reg                                                  |
// | One-entry valid/ready output register for closed trace frames.             |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module sramqsys_cpu_oci_frame_reg
  import oci_trace_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [BUF_W-1:0] i_buf,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_ovf,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [BUF_W-1:0] o_buf,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf
);

  logic             r_valid;
  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  // Payload is cleared on drain so an empty register always reads as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_buf   <= i_buf;
      r_cnt   <= i_cnt;
      r_ovf   <= i_ovf;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_buf   = r_buf;
  assign o_cnt   = r_cnt;
  assign o_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/sramqsys_cpu_oci_dct_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sramqsys_cpu_oci_dct_packer                                                 |
// | Packs 2-bit trace codes into 15-slot frames and hands them downstream.     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module sramqsys_cpu_oci_dct_packer
  import oci_trace_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trace_en,
  input  logic             br_valid,
  input  logic [CODE_W-1:0] br_code,
  input  logic             flush_req,
  output logic             br_ready,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count,
  output logic             frm_valid,
  output logic [BUF_W-1:0] frm_buffer,
  output logic [CNT_W-1:0] frm_count,
  output logic             frm_ovf,
  input  logic             frm_ready
);

  state_t           r_state, w_state_nxt;
  logic [BUF_W-1:0] r_buf, w_buf_nxt, w_base_buf, w_acc_buf, w_ld_buf;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_base_cnt, w_acc_cnt, w_ld_cnt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_en_q;
  logic             w_active, w_code_ok, w_acc, w_drop, w_close_req, w_close;
  logic             w_slot_free, w_load, w_out_valid;

  // In S_HOLD without frm_ready nothing may move: the accumulator is the pending frame.
  assign w_active    = !((r_state == S_HOLD) && !frm_ready);
  assign w_code_ok   = br_valid && trace_en && (br_code != '0);
  assign w_acc       = w_code_ok && w_active;
  assign w_drop      = w_code_ok && !w_active;
  assign w_close_req = flush_req || (r_en_q && !trace_en);

  always_comb begin
    w_base_buf  = r_buf;
    w_base_cnt  = r_cnt;
    w_slot_free = !w_out_valid || frm_ready;
    w_load      = 1'b0;
    w_ld_buf    = r_buf;
    w_ld_cnt    = r_cnt;
    w_close     = 1'b0;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    w_ovf_nxt   = r_ovf | w_drop;

    // Releasing a held frame consumes the output slot; the accumulator restarts empty.
    if ((r_state == S_HOLD) && frm_ready) begin
      w_load      = 1'b1;
      w_base_buf  = '0;
      w_base_cnt  = '0;
      w_slot_free = 1'b0;
    end

    w_acc_buf = w_acc ? {w_base_buf[BUF_W-CODE_W-1:0], br_code} : w_base_buf;
    w_acc_cnt = w_base_cnt + {{(CNT_W-1){1'b0}}, w_acc};

    if (w_active) begin
      w_close = (w_acc_cnt == CNT_W'(SLOTS)) || (w_close_req && (w_acc_cnt != '0));
      if (w_close && w_slot_free) begin
        w_load      = 1'b1;
        w_ld_buf    = w_acc_buf;
        w_ld_cnt    = w_acc_cnt;
        w_buf_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end else if (w_close) begin
        w_buf_nxt   = w_acc_buf;
        w_cnt_nxt   = w_acc_cnt;
        w_state_nxt = S_HOLD;
      end else begin
        w_buf_nxt   = w_acc_buf;
        w_cnt_nxt   = w_acc_cnt;
        w_state_nxt = (w_acc_cnt == '0) ? S_IDLE : S_FILL;
      end
    end

    // A drop coinciding with a load belongs to the following frame.
    if (w_load) begin
      w_ovf_nxt = w_drop;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_en_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
      r_en_q  <= trace_en;
    end
  end

  sramqsys_cpu_oci_frame_reg u_frame_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_buf   (w_ld_buf),
    .i_cnt   (w_ld_cnt),
    .i_ovf   (r_ovf),
    .i_ready (frm_ready),
    .o_valid (w_out_valid),
    .o_buf   (frm_buffer),
    .o_cnt   (frm_count),
    .o_ovf   (frm_ovf)
  );

  // A held frame is already closed, so the live view reads empty.
  assign br_ready   = reset_n && w_active;
  assign dct_buffer = (r_state == S_HOLD) ? '0 : r_buf;
  assign dct_count  = (r_state == S_HOLD) ? '0 : r_cnt;
  assign frm_valid  = w_out_valid;

endmodule
`default_nettype wire
